instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage feeding the ADDI decode/execute datapath.
//  Holds the PC and a word-addressed instruction memory, loaded through a
//  program port. Presents one 32-bit instruction per valid/ready handshake
//  to the downstream splitter. Stops at a HALT opcode.
// PARAMETERS
//  ADDR_W       8      imem depth = 2**ADDR_W words; word index = pc[ADDR_W+1:2]
//  RESET_PC     32'h0  PC value after reset and on every start
//  HALT_OPCODE  6'h3F  inst[31:26] value that ends fetch (never forwarded)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  prog_we     in   1       imem write enable (allowed in any state)
//  prog_addr   in   ADDR_W  imem word index for write
//  prog_data   in   32      imem write data
//  start       in   1       begin fetching at RESET_PC (IDLE/HALT only)
//  inst        out  32      instruction to decode; stable while valid&&!ready
//  inst_valid  out  1       inst holds an unconsumed instruction
//  inst_ready  in   1       downstream accepts inst this cycle
//  pc          out  32      address of the next word to fetch
//  halted      out  1       high in HALT state
// BEHAVIOUR
//  Reset (async, any time, incl. mid-fetch): state=IDLE, pc=RESET_PC,
//   inst=0, inst_valid=0, halted=0. imem contents are not reset.
//  imem: 32-bit words, write synchronous on prog_we, read combinational.
//   Same-edge write and fetch to one index: fetch gets the OLD word.
//  FSM states IDLE, FETCH, HALT:
//   IDLE : start -> FETCH, pc<=RESET_PC. No fetch this edge.
//   FETCH: load = !inst_valid || inst_ready. On an edge with load=1:
//     w = imem[pc[ADDR_W+1:2]];
//     if w[31:26]!=HALT_OPCODE: inst<=w, inst_valid<=1, pc<=pc+4.
//     else: inst_valid<=0, pc unchanged (stays at the HALT word),
//       state<=HALT.
//     load=0 (stall): inst, inst_valid and pc hold.
//     start is ignored in FETCH.
//   HALT : halted=1, inst_valid=0, inst holds the last value.
//     start -> FETCH, pc<=RESET_PC, halted<=0.
//  Latency: start at edge N -> first inst_valid=1 after edge N+1.
//   With inst_ready held high, one new instruction per cycle.
//  Handshake: a transfer occurs on an edge with inst_valid&&inst_ready.
//   inst_valid never drops without a transfer, except on reset.
//  Width: pc is 32 bits, +4 modulo 2**32. The imem index wraps modulo
//   2**ADDR_W, so fetch continues from word 0 after the top word.
//  pc[1:0] stays 0 unless RESET_PC is unaligned. The low bits are ignored
//   for addressing.
// TESTING
//  1 Load imem[0..2]=ADDI words, imem[3]=32'hFC000000, ready=1, start
//    -> inst = w0,w1,w2 on 3 consecutive cycles, then valid=0, halted=1,
//    pc=32'hC.
//  2 Same program, ready=0 for 4 cycles after first valid -> inst=w0 held,
//    pc=4 held. Raise ready -> w1 follows the next cycle. No word lost or
//    duplicated.
//  3 ADDR_W=2, no HALT word, ready=1 -> index sequence 0,1,2,3,0,1.
//    pc = 0,4,8,C,10,14 (index wraps, pc does not).
//  4 Assert reset asynchronously while inst_valid=1, mid-cycle -> outputs
//    clear immediately. After release, start refetches from imem[0].
//  5 prog_we to index 1 on the edge that fetches index 1 -> the old word is
//    delivered. Restart after HALT -> the new word is delivered.
//  6 start pulsed in FETCH -> ignored, sequence unchanged.
//    start in HALT -> refetch from RESET_PC, halted=0.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC, word-addressed instruction memory and valid/ready fetch FSM
//            that stops on a HALT opcode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              start,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       pc,
    output logic              halted
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic        r_inst_valid;
    logic        w_inst_valid_nxt;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] w_word;
    logic        w_load;

    // Contents are deliberately not reset; a same-edge write is seen by the
    // following fetch only, because the read below is of the current array.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    assign w_word = r_mem[r_pc[ADDR_W+1:2]];
    assign w_load = !r_inst_valid || inst_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_valid_nxt = r_inst_valid;
        case (r_state)
            S_IDLE: begin
                w_inst_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = RESET_PC;
                end
            end
            S_FETCH: begin
                if (w_load) begin
                    if (w_word[31:26] != HALT_OPCODE) begin
                        w_inst_nxt       = w_word;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + 32'd4;
                    end else begin
                        // PC parks on the HALT word; it is never forwarded.
                        w_inst_valid_nxt = 1'b0;
                        w_state_nxt      = S_HALT;
                    end
                end
            end
            S_HALT: begin
                w_inst_valid_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = RESET_PC;
                end
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_inst_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign halted     = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch (default and
//            ADDR_W=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_W0   = 32'h20010005;
    localparam logic [31:0] c_W1   = 32'h20020007;
    localparam logic [31:0] c_W2   = 32'h20230003;
    localparam logic [31:0] c_HALT = 32'hFC000000;
    localparam logic [31:0] c_NEW  = 32'h2044000A;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic        halted;

    logic        prog_we2;
    logic [1:0]  prog_addr2;
    logic [31:0] prog_data2;
    logic        start2;
    logic [31:0] inst2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] pc2;
    logic        halted2;

    int n_checks;
    int n_pass;

    instr_fetch #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .inst(inst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc),
        .halted(halted)
    );

    instr_fetch #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .prog_we(prog_we2), .prog_addr(prog_addr2),
        .prog_data(prog_data2), .start(start2), .inst(inst2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .pc(pc2),
        .halted(halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog1(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic prog2(input logic [1:0] a, input logic [31:0] d);
        prog_we2 = 1'b1; prog_addr2 = a; prog_data2 = d;
        tick();
        prog_we2 = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; inst_ready = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0;
        start2 = 1'b0; inst_ready2 = 1'b1;
        tick(); tick();
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        reset = 1'b0;
        tick();

        prog1(8'd0, c_W0); prog1(8'd1, c_W1); prog1(8'd2, c_W2); prog1(8'd3, c_HALT);
        for (int i = 0; i < 4; i++) prog2(i[1:0], 32'h20000100 + i);

        // Streaming run with a start pulse while fetching.
        pulse_start();
        check("t1_latency_valid", {31'b0, inst_valid}, 32'h0);
        check("t1_start_pc", pc, 32'h0);
        tick();
        check("t1_w0", inst, c_W0);
        check("t1_w0_valid", {31'b0, inst_valid}, 32'h1);
        check("t1_w0_pc", pc, 32'h4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_w1_after_start", inst, c_W1);
        check("t6_w1_pc", pc, 32'h8);
        tick();
        check("t1_w2", inst, c_W2);
        check("t1_w2_pc", pc, 32'hC);
        tick();
        check("t1_halt_valid", {31'b0, inst_valid}, 32'h0);
        check("t1_halted", {31'b0, halted}, 32'h1);
        check("t1_halt_pc", pc, 32'hC);
        check("t1_inst_hold", inst, c_W2);
        tick();
        check("t1_halt_stays", {31'b0, halted}, 32'h1);

        // Restart from HALT, then stall with ready low.
        pulse_start();
        check("t6_restart_halted", {31'b0, halted}, 32'h0);
        check("t6_restart_pc", pc, 32'h0);
        inst_ready = 1'b0;
        tick();
        check("t2_w0", inst, c_W0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_stall_inst", inst, c_W0);
            check("t2_stall_pc", pc, 32'h4);
            check("t2_stall_valid", {31'b0, inst_valid}, 32'h1);
        end
        inst_ready = 1'b1;
        tick();
        check("t2_w1", inst, c_W1);
        check("t2_w1_pc", pc, 32'h8);
        tick();
        check("t2_w2", inst, c_W2);
        tick();
        check("t2_halted", {31'b0, halted}, 32'h1);

        // Write index 1 on the very edge that fetches it.
        pulse_start();
        tick();
        check("t5_w0", inst, c_W0);
        prog_we = 1'b1; prog_addr = 8'd1; prog_data = c_NEW;
        tick();
        prog_we = 1'b0;
        check("t5_old_word", inst, c_W1);
        tick(); tick();
        check("t5_halted", {31'b0, halted}, 32'h1);
        pulse_start();
        tick();
        check("t5_re_w0", inst, c_W0);
        tick();
        check("t5_new_word", inst, c_NEW);

        // Asynchronous reset in the middle of a cycle with valid high.
        check("t4_pre_valid", {31'b0, inst_valid}, 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("t4_async_valid", {31'b0, inst_valid}, 32'h0);
        check("t4_async_inst", inst, 32'h0);
        check("t4_async_pc", pc, 32'h0);
        check("t4_async_halted", {31'b0, halted}, 32'h0);
        #2;
        reset = 1'b0;
        tick();
        check("t4_idle_valid", {31'b0, inst_valid}, 32'h0);
        pulse_start();
        tick();
        check("t4_refetch_w0", inst, c_W0);
        check("t4_refetch_pc", pc, 32'h4);

        // ADDR_W=2 instance: index wraps, pc keeps counting.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t3_wrap_inst", inst2, 32'h20000100 + (i % 4));
            check("t3_wrap_pc", pc2, 32'(4 * (i + 1)));
        end
        check("t3_valid", {31'b0, inst_valid2}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
